quad_gen: RTL

//  Quadrature encoder emulator: the transmit side of the encoder interface that the mixer decodes.

---
 rtl/quad_gen.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/quad_gen.sv
// quad_gen: quadrature encoder emulator.
// Takes step commands (direction, count, pace) over valid/ready and drives a
// Gray-coded A/B waveform that a downstream debounce+encoder chain counts
// +/-1 per step. Rest phase after each step alternates 00 / 11.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; ready only while idle
//   cmd_dir               1 = up (A leads B), 0 = down (B leads A)
//   cmd_steps             number of steps (0 allowed)
//   cmd_period            clocks between edges (0 treated as 1)
//   abort                 finish the step in progress, then stop
//   enc_a, enc_b          registered quadrature outputs
//   busy                  ~cmd_ready
//   done                  one-cycle pulse at the end of a command
//   position              net step count, wraps mod 2^WIDTH
//
// Optional build macro QUAD_GEN_BOUNCE_EN: before each edge the moving line
// chatters for min(BOUNCE_LEN, period-1) clocks (new, old, new, ...) and
// settles at the new value on the edge itself.
module quad_gen #(
  parameter int WIDTH      = 8,
  parameter int PERIOD_W   = 16,
  parameter int BOUNCE_LEN = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [WIDTH-1:0]    cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic                enc_a,
  output logic                enc_b,
  output logic                busy,
  output logic                done,
  output logic [WIDTH-1:0]    position
);

  // ST_ZERO holds off the handshake for one cycle on a zero-step command so
  // done and cmd_ready rise together; ST_FIN keeps busy for the cycle that
  // carries the done pulse of a non-empty command.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDGE1,
    ST_EDGE2,
    ST_FIN,
    ST_ZERO
  } state_t;

  state_t              state_q, state_d;
  logic                dir_q, dir_d;
  logic [WIDTH-1:0]    steps_q, steps_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                abort_q, abort_d;
  logic                a_q, a_d;
  logic                b_q, b_d;
  logic                done_q, done_d;
  logic [WIDTH-1:0]    pos_q, pos_d;
  logic                edge_due;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b0;
      steps_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      abort_q  <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      done_q   <= 1'b0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      steps_q  <= steps_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      abort_q  <= abort_d;
      a_q      <= a_d;
      b_q      <= b_d;
      done_q   <= done_d;
      pos_q    <= pos_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    steps_d  = steps_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    a_d      = a_q;
    b_d      = b_q;
    done_d   = 1'b0;
    pos_d    = pos_q;
    edge_due = (cnt_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_d    = cmd_dir;
          period_d = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
          cnt_d    = period_d - PERIOD_W'(1);
          steps_d  = cmd_steps;
          abort_d  = 1'b0;
          state_d  = (cmd_steps == '0) ? ST_ZERO : ST_EDGE1;
        end
      end

      ST_EDGE1: begin
        if (abort) abort_d = 1'b1;
        if (edge_due) begin
          // First edge of a step: this is the edge the decoder counts.
          if (dir_q) begin
            a_d   = ~a_q;
            pos_d = pos_q + WIDTH'(1);
          end else begin
            b_d   = ~b_q;
            pos_d = pos_q - WIDTH'(1);
          end
          cnt_d   = period_q - PERIOD_W'(1);
          state_d = ST_EDGE2;
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end

      ST_EDGE2: begin
        if (abort) abort_d = 1'b1;
        if (edge_due) begin
          if (dir_q) b_d = ~b_q;
          else       a_d = ~a_q;
          if (steps_q == WIDTH'(1) || abort_d) begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            steps_d = steps_q - WIDTH'(1);
            cnt_d   = period_q - PERIOD_W'(1);
            state_d = ST_EDGE1;
          end
        end else begin
          cnt_d = cnt_q - PERIOD_W'(1);
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      ST_ZERO: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign done      = done_q;
  assign position  = pos_q;

`ifdef QUAD_GEN_BOUNCE_EN
  localparam logic [PERIOD_W-1:0] BL = PERIOD_W'(BOUNCE_LEN);

  logic [PERIOD_W-1:0] blen;
  logic [PERIOD_W-1:0] phase;
  logic                move_a;
  logic                in_edge;
  logic                show_new;
  logic                enc_a_d, enc_b_d;

  // a_q/b_q hold the settled line levels. cnt_q equals the number of clocks
  // left before the edge, so the chatter window is 1 <= cnt_q <= blen and the
  // first clock of the window (cnt_q == blen) shows the new level.
  always_comb begin
    blen     = (BL < period_q - PERIOD_W'(1)) ? BL : period_q - PERIOD_W'(1);
    phase    = blen - cnt_q;
    move_a   = ((state_q == ST_EDGE1) == dir_q);
    in_edge  = (state_q == ST_EDGE1) || (state_q == ST_EDGE2);
    show_new = in_edge && (cnt_q != '0) && (cnt_q <= blen) && !phase[0];
    enc_a_d  = a_d ^ (show_new & move_a);
    enc_b_d  = b_d ^ (show_new & ~move_a);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_a <= 1'b0;
      enc_b <= 1'b0;
    end else begin
      enc_a <= enc_a_d;
      enc_b <= enc_b_d;
    end
  end
`else
  assign enc_a = a_q;
  assign enc_b = b_q;
`endif

endmodule
